// File: rtl/ca_frame_writer.sv
// Write side of the 1-bit VGA frame buffer. Each frame is cleared, then an
// elementary cellular automaton is written one generation per screen row.
//
// state | meaning
// IDLE  | after reset, waiting for iStart
// CLEAR | writing 0 to every pixel, one per clock
// SEED  | building generation 0 in cur_q, no writes
// ROW   | writing cur_q to row oRow while computing the next generation
// WAIT  | single-step mode, row finished, waiting for iStep/iStart
// DONE  | frame full, waiting for iStart
module ca_frame_writer #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iStart,
  input  logic              iStep,
  input  logic              iRun,
  input  logic [7:0]        iRule,
  input  logic              iSeedRand,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oData,
  output logic              oWe,
  output logic              oBusy,
  output logic [8:0]        oRow,
  output logic              oDone
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [XW-1:0]     X_LAST    = XW'(WIDTH - 1);
  localparam logic [XW-1:0]     X_MID     = XW'(WIDTH / 2);
  localparam logic [8:0]        ROW_LAST  = 9'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SEED, S_ROW, S_WAIT, S_DONE
  } state_t;

  state_t            state_q;
  logic [XW-1:0]     x_q;
  logic [WIDTH-1:0]  cur_q, nxt_q, nxt_d;
  logic [7:0]        rule_q;
  logic              seed_rand_q;
  logic [31:0]       lfsr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              data_q, we_q, busy_q, done_q;
  logic [8:0]        row_q;
  logic [XW-1:0]     x_left, x_right;
  logic [2:0]        nbhd;

  // Neighbourhood wraps around the row ends.
  always_comb begin
    x_left  = (x_q == '0) ? X_LAST : x_q - 1'b1;
    x_right = (x_q == X_LAST) ? '0 : x_q + 1'b1;
    nbhd    = {cur_q[x_left], cur_q[x_q], cur_q[x_right]};
    nxt_d   = nxt_q;
    nxt_d[x_q] = rule_q[nbhd];
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) lfsr_q <= 32'h0000_0001;
    else         lfsr_q <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      rule_q      <= '0;
      seed_rand_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      row_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_WAIT, S_DONE: begin
          if (iStart) begin
            state_q     <= S_CLEAR;
            rule_q      <= iRule;
            seed_rand_q <= iSeedRand;
            addr_q      <= '0;
            data_q      <= 1'b0;
            we_q        <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            row_q       <= '0;
          end else if (state_q == S_WAIT && iStep) begin
            // addr_q still holds the last pixel of the previous row
            state_q <= S_ROW;
            x_q     <= '0;
            addr_q  <= addr_q + 1'b1;
            data_q  <= cur_q[0];
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (addr_q == ADDR_LAST) begin
            state_q <= S_SEED;
            x_q     <= '0;
            we_q    <= 1'b0;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        S_SEED: begin
          cur_q[x_q] <= seed_rand_q ? lfsr_q[0] : (x_q == X_MID);
          if (x_q == X_LAST) begin
            state_q <= S_ROW;
            x_q     <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            data_q  <= cur_q[0];
            we_q    <= 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
        S_ROW: begin
          nxt_q <= nxt_d;
          if (x_q != X_LAST) begin
            x_q    <= x_q + 1'b1;
            addr_q <= addr_q + 1'b1;
            data_q <= cur_q[x_q + 1'b1];
          end else begin
            cur_q <= nxt_d;
            x_q   <= '0;
            if (row_q == ROW_LAST) begin
              state_q <= S_DONE;
              we_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              row_q <= row_q + 1'b1;
              if (iRun) begin
                addr_q <= addr_q + 1'b1;
                data_q <= nxt_d[0];
              end else begin
                state_q <= S_WAIT;
                we_q    <= 1'b0;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oAddr = addr_q;
  assign oData = data_q;
  assign oWe   = we_q;
  assign oBusy = busy_q;
  assign oRow  = row_q;
  assign oDone = done_q;

endmodule

// File: tb/tb_ca_frame_writer.sv
// Directed-plus-random bench for ca_frame_writer on a reduced 32x24 frame.
// Observed writes are mirrored into a local frame buffer and compared with a CA reference.
module tb_ca_frame_writer;

  localparam int W     = 32;
  localparam int H     = 24;
  localparam int AW    = 10;
  localparam int TOTAL = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          run = 1'b0;
  logic [7:0]    rule = 8'd0;
  logic          seed_rand = 1'b0;
  logic [AW-1:0] addr;
  logic          data, we, busy, done;
  logic [8:0]    row;

  ca_frame_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iStep(step), .iRun(run),
    .iRule(rule), .iSeedRand(seed_rand),
    .oAddr(addr), .oData(data), .oWe(we), .oBusy(busy), .oRow(row), .oDone(done)
  );

  always #5 clk = ~clk;

  // Reference LFSR and cycle counter, advanced on the same edges as the design.
  logic [31:0] lfsr_m = 32'h1;
  int          cyc = 0;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    lfsr_m <= !rst_n ? 32'h1 : {lfsr_m[30:0], lfsr_m[31] ^ lfsr_m[21] ^ lfsr_m[1] ^ lfsr_m[0]};
  end

  // Write monitor: mirrors the buffer and tracks ordering/timing of writes.
  bit fb[TOTAL];
  bit seed_bits[W];
  int wr_cnt = 0, seq_err = 0, bad_addr = 0, clear_dirty = 0, we_no_busy = 0;
  int exp_addr = 0, seed_left = 0;
  int clear_end_cyc = 0, row_first_cyc = 0, row_last_cyc = 0;
  int clr_gen = 0, seen_gen = 0;

  always @(negedge clk) begin
    if (clr_gen != seen_gen) begin
      seen_gen    <= clr_gen;
      wr_cnt      <= 0;
      seq_err     <= 0;
      bad_addr    <= 0;
      clear_dirty <= 0;
      we_no_busy  <= 0;
      exp_addr    <= 0;
      seed_left   <= 0;
    end else begin
      if (seed_left > 0) begin
        seed_bits[W - seed_left] <= lfsr_m[0];
        seed_left <= seed_left - 1;
      end
      if (we === 1'b1) begin
        if (int'(addr) >= TOTAL) bad_addr <= bad_addr + 1;
        else fb[addr] <= data;
        if (int'(addr) != exp_addr) seq_err <= seq_err + 1;
        exp_addr <= (exp_addr == TOTAL - 1) ? 0 : exp_addr + 1;
        if (busy !== 1'b1) we_no_busy <= we_no_busy + 1;
        if (wr_cnt < TOTAL && data !== 1'b0) clear_dirty <= clear_dirty + 1;
        if (wr_cnt == TOTAL - 1) begin
          clear_end_cyc <= cyc;
          seed_left     <= W;
        end
        if (wr_cnt == TOTAL) row_first_cyc <= cyc;
        row_last_cyc <= cyc;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; tick(1); step = 1'b0;
  endtask

  task automatic mon_clear();
    clr_gen++;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin tick(1); n++; end
    chk(tag, done, 1);
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (wr_cnt < target && n < budget) begin tick(1); n++; end
    chk(tag, wr_cnt, target);
  endtask

  task automatic count_we(input int n, output int c, output int b);
    c = 0; b = 0;
    repeat (n) begin
      tick(1);
      if (we !== 1'b0) c++;
      if (busy !== 1'b0) b++;
    end
  endtask

  // Elementary CA: generation y+1 cell x = rule bit (4*left + 2*centre + right), wrapping.
  function automatic int frame_mismatch(input logic [7:0] r, input logic [W-1:0] seed);
    logic [W-1:0] cur, nxt;
    int m, idx;
    m = 0;
    cur = seed;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) if (fb[y*W + x] !== cur[x]) m++;
      for (int x = 0; x < W; x++) begin
        idx = 4*int'(cur[(x+W-1) % W]) + 2*int'(cur[x]) + int'(cur[(x+1) % W]);
        nxt[x] = r[idx];
      end
      cur = nxt;
    end
    return m;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] seed_one, seed_rnd;
  logic [7:0]   rule_c;
  int           c, b, m, xe;

  initial begin
    seed_one = '0;
    seed_one[W/2] = 1'b1;

    // Reset state
    tick(3);
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_row", row, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    rst_n = 1'b1;
    count_we(10, c, b);
    chk("idle_we", c, 0);

    // Frame A: rule 90, single seed, free-run
    rule = 8'd90; seed_rand = 1'b0; run = 1'b1;
    mon_clear();
    pulse_start();
    chk("A_first_we", we, 1);
    chk("A_first_addr", addr, 0);
    chk("A_first_busy", busy, 1);
    rule = 8'hFF;
    wait_done("A_done", 4000);
    chk("A_done_latency", cyc, row_last_cyc + 1);
    chk("A_clear_dirty", clear_dirty, 0);
    chk("A_seq_err", seq_err, 0);
    chk("A_bad_addr", bad_addr, 0);
    chk("A_we_no_busy", we_no_busy, 0);
    chk("A_writes", wr_cnt, 2*TOTAL);
    chk("A_seed_gap", row_first_cyc - clear_end_cyc, W + 1);
    chk("A_row_span", row_last_cyc - row_first_cyc + 1, TOTAL);
    chk("A_r0_mid", fb[W/2], 1);
    chk("A_r0_left", fb[W/2 - 1], 0);
    chk("A_r1_l", fb[W + W/2 - 1], 1);
    chk("A_r1_mid", fb[W + W/2], 0);
    chk("A_r1_r", fb[W + W/2 + 1], 1);
    chk("A_r2_l", fb[2*W + W/2 - 2], 1);
    chk("A_r2_mid", fb[2*W + W/2], 0);
    chk("A_r2_r", fb[2*W + W/2 + 2], 1);
    chk("A_frame", frame_mismatch(8'd90, seed_one), 0);
    tick(5);
    chk("A_hold_done", done, 1);
    chk("A_hold_row", row, H - 1);
    chk("A_hold_we", we, 0);
    chk("A_hold_busy", busy, 0);

    // Frame B: rule 170 shifts the single cell left, wrapping at x=0
    rule = 8'd170;
    mon_clear();
    pulse_start();
    chk("B_done_drop", done, 0);
    chk("B_first_we", we, 1);
    wait_done("B_done", 4000);
    m = 0;
    for (int r = 0; r < H; r++)
      for (int x = 0; x < W; x++) begin
        xe = ((W/2 - r) % W + W) % W;
        if (fb[r*W + x] !== (x == xe)) m++;
      end
    chk("B_shift_frame", m, 0);
    chk("B_wrap_x0", fb[(W/2)*W], 1);
    chk("B_wrap_xlast", fb[(W/2 + 1)*W + W - 1], 1);
    chk("B_seq_err", seq_err, 0);

    // Frame C: random seed, random rule, single-step then switch to free-run
    rule_c = 8'($urandom_range(0, 255));
    rule = rule_c; seed_rand = 1'b1; run = 1'b0;
    mon_clear();
    pulse_start();
    seed_rand = 1'b0;
    wait_writes("C_row0_writes", TOTAL + W, 3000);
    count_we(40, c, b);
    chk("C_wait_we", c, 0);
    chk("C_wait_busy", b, 0);
    chk("C_wait_row", row, 1);
    rule = ~rule_c;
    pulse_step();
    tick(W + 10);
    chk("C_step_writes", wr_cnt, TOTAL + 2*W);
    chk("C_step_row", row, 2);
    chk("C_step_we", we, 0);
    pulse_step();
    tick(5);
    pulse_start();
    run = 1'b1;
    wait_done("C_done", 3000);
    chk("C_seq_err", seq_err, 0);
    chk("C_writes", wr_cnt, 2*TOTAL);
    for (int x = 0; x < W; x++) seed_rnd[x] = seed_bits[x];
    m = 0;
    for (int x = 0; x < W; x++) if (fb[x] !== seed_rnd[x]) m++;
    chk("C_seed_row", m, 0);
    chk("C_frame", frame_mismatch(rule_c, seed_rnd), 0);

    // Frame D: iStart beats iStep in WAIT, then reset in the middle of row 5
    rule = 8'd90; seed_rand = 1'b0; run = 1'b0;
    mon_clear();
    pulse_start();
    wait_writes("D_row0_writes", TOTAL + W, 3000);
    tick(3);
    mon_clear();
    start = 1'b1; step = 1'b1;
    tick(1);
    start = 1'b0; step = 1'b0;
    chk("D_both_we", we, 1);
    chk("D_both_addr", addr, 0);
    chk("D_both_data", data, 0);
    run = 1'b1;
    c = 0;
    while (!(we === 1'b1 && int'(addr) == 5*W + 10) && c < 3000) begin tick(1); c++; end
    chk("D_reach_row5", (we === 1'b1 && int'(addr) == 5*W + 10), 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("D_rst_we", we, 0);
    chk("D_rst_row", row, 0);
    chk("D_rst_done", done, 0);
    chk("D_rst_busy", busy, 0);
    count_we(20, c, b);
    chk("D_rst_idle_we", c, 0);
    rule = 8'd170;
    mon_clear();
    tick(1);
    pulse_start();
    chk("D_restart_we", we, 1);
    chk("D_restart_addr", addr, 0);
    wait_done("D_done", 4000);
    chk("D_frame", frame_mismatch(8'd170, seed_one), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
